// File: rtl/mem_responder_pkg.sv
// Shared memory-message types for the 4-byte mem request/response protocol
// used between the processor and the memory responder.
package mem_responder_pkg;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

   localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
   localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
   localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;
   localparam logic [1:0] MEM_RESP_TEST  = 2'd0;
   localparam int unsigned MEM_TMR_W     = 4;

endpackage

// File: rtl/mem_responder_latency_queue.sv
// Circular response FIFO where each entry carries a countdown timer; the head
// becomes visible only once its timer has reached zero.
module mem_responder_latency_queue
   import mem_responder_pkg::*;
#(
   parameter int unsigned p_depth   = 2,
   parameter int unsigned p_latency = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enq_val_i,
   output logic         enq_rdy_o,
   input  mem_resp_4B_t enq_msg_i,
   output logic         deq_val_o,
   input  logic         deq_rdy_i,
   output mem_resp_4B_t deq_msg_o
);

   localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int unsigned CW = $clog2(p_depth + 1);

   logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 vld_q [p_depth];
   logic                 vld_d [p_depth];
   logic [MEM_TMR_W-1:0] tmr_q [p_depth];
   logic [MEM_TMR_W-1:0] tmr_d [p_depth];
   mem_resp_4B_t         msg_q [p_depth];
   mem_resp_4B_t         msg_d [p_depth];
   logic                 enq_fire, deq_fire;

   // Depth need not be a power of two, so wrap by explicit compare.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(p_depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign enq_rdy_o = (count_q < CW'(p_depth));
   assign deq_val_o = vld_q[head_q] && (tmr_q[head_q] == '0);
   assign deq_msg_o = msg_q[head_q];
   assign enq_fire  = enq_val_i && enq_rdy_o;
   assign deq_fire  = deq_val_o && deq_rdy_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      vld_d   = vld_q;
      tmr_d   = tmr_q;
      msg_d   = msg_q;
      for (int i = 0; i < int'(p_depth); i++) begin
         if (vld_q[i] && (tmr_q[i] != '0)) tmr_d[i] = tmr_q[i] - 1'b1;
      end
      if (deq_fire) begin
         vld_d[head_q] = 1'b0;
         head_d        = ptr_inc(head_q);
      end
      if (enq_fire) begin
         vld_d[tail_q] = 1'b1;
         tmr_d[tail_q] = MEM_TMR_W'(p_latency);
         msg_d[tail_q] = enq_msg_i;
         tail_d        = ptr_inc(tail_q);
      end
      if (enq_fire && !deq_fire)      count_d = count_q + 1'b1;
      else if (!enq_fire && deq_fire) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(p_depth); i++) vld_q[i] <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Payload and timers are qualified by vld_q, so they need no reset.
   always_ff @(posedge clk) begin
      tmr_q <= tmr_d;
      msg_q <= msg_d;
   end

endmodule

// File: rtl/mem_responder.sv
// Word-organised single-port memory answering mem_req_4B_t requests; the access
// happens at acceptance and the response waits in a fixed-latency queue.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned p_mem_nbytes  = 4096,
   parameter int unsigned p_latency     = 0,
   parameter int unsigned p_queue_depth = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         memreq_val,
   output logic         memreq_rdy,
   input  mem_req_4B_t  memreq_msg,
   output logic         memresp_val,
   input  logic         memresp_rdy,
   output mem_resp_4B_t memresp_msg
);

   localparam int unsigned WORDS = p_mem_nbytes / 4;
   localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic [31:0]  mem_q [WORDS];
   logic [IW-1:0] idx;
   logic [31:0]  word, wdata_d;
   logic         req_fire, is_write, q_enq_rdy, q_deq_val;
   mem_resp_4B_t resp, q_deq_msg;

   function automatic logic [31:0] read_lanes(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] len);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (len)
         2'd1:    return {24'd0, sh[7:0]};
         2'd2:    return {16'd0, sh[15:0]};
         2'd3:    return {8'd0, sh[23:0]};
         default: return sh;
      endcase
   endfunction

   // Source bytes landing past lane 3 are dropped; nothing spills to the next word.
   function automatic logic [31:0] write_lanes(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] off, input logic [1:0] len);
      logic [31:0] r;
      int          o, nb;
      r  = w;
      o  = int'(off);
      nb = (len == 2'd0) ? 4 : int'(len);
      for (int j = 0; j < 4; j++) begin
         if ((j < nb) && (o + j < 4)) r[8*(o+j) +: 8] = d[8*j +: 8];
      end
      return r;
   endfunction

   assign idx        = IW'((memreq_msg.addr >> 2) & (WORDS - 1));
   assign word       = mem_q[idx];
   assign memreq_rdy = reset && q_enq_rdy;
   assign req_fire   = memreq_val && memreq_rdy;
   assign is_write   = (memreq_msg.type_ == MEM_TYPE_WRITE) || (memreq_msg.type_ == MEM_TYPE_INIT);
   assign wdata_d    = write_lanes(word, memreq_msg.data, memreq_msg.addr[1:0], memreq_msg.len);

   always_comb begin
      resp        = '0;
      resp.type_  = memreq_msg.type_;
      resp.opaque = memreq_msg.opaque;
      resp.test   = MEM_RESP_TEST;
      resp.len    = memreq_msg.len;
      if (memreq_msg.type_ == MEM_TYPE_READ)
         resp.data = read_lanes(word, memreq_msg.addr[1:0], memreq_msg.len);
   end

   always_ff @(posedge clk) begin
      if (req_fire && is_write) mem_q[idx] <= wdata_d;
   end

   mem_responder_latency_queue #(
      .p_depth   (p_queue_depth),
      .p_latency (p_latency)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .enq_val_i (req_fire),
      .enq_rdy_o (q_enq_rdy),
      .enq_msg_i (resp),
      .deq_val_o (q_deq_val),
      .deq_rdy_i (memresp_rdy),
      .deq_msg_o (q_deq_msg)
   );

   assign memresp_val = reset && q_deq_val;
   assign memresp_msg = reset ? q_deq_msg : '0;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Single-port word memory that services the processor's mem request/response protocol; it is the responder end of the imem/dmem ports.
- It accepts mem_req_4B_t requests over val/rdy and performs the access at acceptance.
- It returns mem_resp_4B_t responses in order, after a programmable fixed latency, through a small response queue.
- It is used as the instruction/data memory behind the pipelined processor in simulation and as a standalone memory in unit benches.

Parameters:
- p_mem_nbytes, 4096: memory size in bytes; power of two, at least 4; word-organised (p_mem_nbytes/4 words).
- p_latency, 0: extra cycles a response waits in the queue before it becomes visible; range 0..15.
- p_queue_depth, 2: number of response queue entries; range 1..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = in reset).
- memreq_val  input  1  request valid.
- memreq_rdy  output  1  request ready.
- memreq_msg  input  77  mem_req_4B_t {type 3, opaque 8, addr 32, len 2, data 32}.
- memresp_val  output  1  response valid.
- memresp_rdy  input  1  response ready.
- memresp_msg  output  47  mem_resp_4B_t {type 3, opaque 8, test 2, len 2, data 32}.

Behaviour:
- Reset (reset==0 at an edge):
  - All queue entries invalidated; count=0.
  - While reset is asserted, memreq_rdy=0, memresp_val=0 and memresp_msg=0.
  - memreq_rdy rises to 1 in the first cycle after reset deasserts.
  - Memory array is not cleared; contents are loaded with INIT requests.
- Handshakes:
  - A transfer occurs on a cycle where val&rdy.
  - memreq_rdy = (count < p_queue_depth). There is no same-cycle bypass from response dequeue.
  - memresp_val depends only on registered state. It is never combinationally dependent on memreq_val.
- Access at acceptance edge:
  - word index = addr[log2(p_mem_nbytes)-1:2]; upper address bits are ignored, so addresses wrap modulo p_mem_nbytes.
  - nbytes = (len==0) ? 4 : len. Byte offset = addr[1:0].
  - Lanes beyond byte 3 are dropped; there is no cross-word access.
- Per request type:
  - READ (0): resp.data = (word >> 8*offset) masked to nbytes, zero-extended.
  - WRITE (1) and INIT (2): write data[8*nbytes-1:0] into lanes offset..; resp.data=0.
  - Other types (AMO): no state change; resp.data=0.
- Response fields: resp.type, opaque and len are copied from the request; resp.test=0.
- Ordering:
  - Write and read side effects commit at the accept edge, in request order.
  - A read accepted the cycle after a write to the same word returns the new data.
- Latency queue:
  - The queue is a circular FIFO: head and tail pointers plus count.
  - Each entry holds {resp_msg, 4-bit timer}. On enqueue, timer=p_latency.
  - Every cycle, each valid entry with timer!=0 decrements its timer; a timer at 0 saturates.
  - memresp_val = head valid && head timer==0; memresp_msg = head msg.
  - Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
  - Pointers wrap at p_queue_depth. p_queue_depth need not be a power of two, so wrap is an explicit compare.
- Latency and throughput:
  - A request accepted at edge t produces a response visible from cycle t+1+p_latency, provided it is at the head.
  - Sustained one-request-per-cycle throughput requires p_queue_depth >= p_latency+2.
- Backpressure: when memresp_rdy=0, the head holds stable, including msg; the queue fills; memreq_rdy drops at count==p_queue_depth.
- Reset mid-operation: in-flight responses are discarded. Writes already accepted remain in memory.

Decomposition:
- Message types come from the shared mem-msgs package: mem_req_4B_t, mem_resp_4B_t, and type constants READ=0, WRITE=1, INIT=2.
- Add a localparam for response test=0 there.
- Sub-module mem_responder_latency_queue, parameterised on depth and latency, with enq val/rdy/msg and deq val/rdy/msg.
- The top holds the memory array, lane mask/shift logic and response formation.

Test Plan:
- INIT 0x1000 data 0xdeadbeef len 0, then READ 0x1000 len 0 with resp_rdy=1 and p_latency=0 -> responses on consecutive cycles: type 2 data 0, then type 0 data 0xdeadbeef, with opaque echoed.
- After the previous init, READ 0x1001 len 1 -> data 0x000000be. WRITE 0x1002 len 2 data 0x1234, then READ 0x1000 len 0 -> 0x1234beef.
- p_latency=3, p_queue_depth=5, 8 back-to-back READs -> first memresp_val is 4 cycles after the first accept. Then one response per cycle, opaques 0..7 in order, memreq_rdy never drops.
- p_queue_depth=2, memresp_rdy=0, 4 requests offered -> 2 accepted, memreq_rdy=0, memresp_msg stable. Raise memresp_rdy -> the remaining 2 are accepted and all 4 responses arrive in order.
- Assert reset for 1 cycle with 2 responses queued -> memresp_val=0 the next cycle and memreq_rdy=1 after reset releases. A prior WRITE of 0xcafef00d to 0x2000 still reads back.
- Address 0x1000+p_mem_nbytes -> aliases to 0x1000. A READ to 0x1003 len 2 -> returns byte 3 only, upper bytes 0.
